branch_predictor_btb: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage pipeline: direct-mapped BTB plus a

---
 rtl/branch_predictor_btb_pkg.sv | 23 ++
 rtl/branch_predictor_btb_sat_counter.sv | 21 ++
 rtl/branch_predictor_btb.sv | 133 +++++++++++++
 tb/tb_branch_predictor_btb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch predictor: mode encodings, table
// geometry helpers and the PHT counter reset value.
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Index width: one BTB/PHT entry per word-aligned PC slot.
  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers every PC bit above the index and the ignored byte offset.
  function automatic int tag_bits(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Counters start weakly not-taken: just below the taken threshold.
  function automatic int ctr_reset(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter step: purely combinational next value for one
// PHT entry, clamped at 0 and at all-ones.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                inc,
  output logic [CTR_BITS-1:0] result
);

  // Step toward taken or not-taken, holding at either end of the range.
  always_comb begin
    result = value;
    if (inc) begin
      if (value != {CTR_BITS{1'b1}}) result = value + CTR_BITS'(1);
    end else begin
      if (value != {CTR_BITS{1'b0}}) result = value - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: direct-mapped BTB with a PHT of saturating
// counters, indexed bimodally or gshare-style. IF looks up combinationally;
// EX resolutions train the tables and repair the global history.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 32,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 5,
  parameter int MODE     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     if_pc,
  input  logic                if_advance,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [XLEN-1:0]     upd_pc,
  input  logic                upd_is_cond,
  input  logic                upd_taken,
  input  logic [XLEN-1:0]     upd_target,
  input  logic                upd_mispredict,
  input  logic [GHR_BITS-1:0] upd_ghr,
  output logic [31:0]         perf_updates,
  output logic [31:0]         perf_mispred
);

  localparam int IDX = idx_bits(ENTRIES);
  localparam int TAG = tag_bits(XLEN, ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset(CTR_BITS));

  // Tables are flop arrays so the lookup can be an asynchronous read.
  logic                valid_reg   [ENTRIES];
  logic [TAG-1:0]      tag_reg     [ENTRIES];
  logic [XLEN-1:0]     target_reg  [ENTRIES];
  logic                is_cond_reg [ENTRIES];
  logic [CTR_BITS-1:0] ctr_reg     [ENTRIES];

  logic [GHR_BITS-1:0] ghr_reg, ghr_next;
  logic [31:0]         perf_updates_reg, perf_mispred_reg;

  logic [IDX-1:0]      if_idx, if_pht_idx, upd_idx, upd_pht_idx;
  logic [TAG-1:0]      if_tag, upd_tag;
  logic                if_hit, if_cond_hit, btb_wr, pht_wr;
  logic [CTR_BITS-1:0] if_ctr, upd_ctr_next;
  logic                unused_pc_bits;

  // Byte offset within the word never affects prediction.
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup side: BTB indexed by PC, PHT optionally folded with history.
  assign if_idx      = if_pc[IDX+1:2];
  assign if_tag      = if_pc[XLEN-1:IDX+2];
  assign if_pht_idx  = (MODE == MODE_GSHARE) ? (if_idx ^ IDX'(ghr_reg)) : if_idx;
  assign if_hit      = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign if_ctr      = ctr_reg[if_pht_idx];
  assign if_cond_hit = if_hit && is_cond_reg[if_idx];
  assign pred_taken  = if_hit && (!is_cond_reg[if_idx] || if_ctr[CTR_BITS-1]);
  assign pred_target = target_reg[if_idx];
  assign pred_ghr    = ghr_reg;

  // Update side: the PHT index uses the history the branch was predicted with.
  assign upd_idx     = upd_pc[IDX+1:2];
  assign upd_tag     = upd_pc[XLEN-1:IDX+2];
  assign upd_pht_idx = (MODE == MODE_GSHARE) ? (upd_idx ^ IDX'(upd_ghr)) : upd_idx;
  assign btb_wr      = upd_valid && upd_taken;
  assign pht_wr      = upd_valid && upd_is_cond;

  sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_counter (
    .value  (ctr_reg[upd_pht_idx]),
    .inc    (upd_taken),
    .result (upd_ctr_next)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      // Valid bit: cleared by reset, set when a taken resolution allocates.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) valid_reg[gi] <= 1'b0;
        else if (btb_wr && (upd_idx == IDX'(gi))) valid_reg[gi] <= 1'b1;
      end

      // PHT counter: trained only by conditional branches.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) ctr_reg[gi] <= CTR_INIT;
        else if (pht_wr && (upd_pht_idx == IDX'(gi))) ctr_reg[gi] <= upd_ctr_next;
      end
    end
  endgenerate

  // BTB payload: don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      tag_reg[upd_idx]     <= upd_tag;
      target_reg[upd_idx]  <= upd_target;
      is_cond_reg[upd_idx] <= upd_is_cond;
    end
  end

  // History: mispredict repair wins over the speculative fetch-time shift.
  always_comb begin
    ghr_next = ghr_reg;
    if (upd_valid && upd_mispredict) begin
      if (upd_is_cond) ghr_next = (upd_ghr << 1) | GHR_BITS'(upd_taken);
      else             ghr_next = upd_ghr;
    end else if (if_advance && if_cond_hit) begin
      ghr_next = (ghr_reg << 1) | GHR_BITS'(pred_taken);
    end
  end

  // History register and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_reg          <= '0;
      perf_updates_reg <= '0;
      perf_mispred_reg <= '0;
    end else begin
      ghr_reg <= ghr_next;
      if (upd_valid && (perf_updates_reg != 32'hFFFF_FFFF))
        perf_updates_reg <= perf_updates_reg + 32'd1;
      if (upd_valid && upd_mispredict && (perf_mispred_reg != 32'hFFFF_FFFF))
        perf_mispred_reg <= perf_mispred_reg + 32'd1;
    end
  end

  assign perf_updates = perf_updates_reg;
  assign perf_mispred = perf_mispred_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: a bimodal and a gshare instance share all inputs; each
// check prints one line and mismatches are tallied for the summary.
module tb_branch_predictor_btb;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_advance;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [4:0]  upd_ghr;

  logic        bim_taken, gs_taken;
  logic [31:0] bim_target, gs_target;
  logic [4:0]  bim_ghr, gs_ghr;
  logic [31:0] bim_updates, gs_updates, bim_mispred, gs_mispred;

  int n_total = 0;
  int n_bad   = 0;

  branch_predictor_btb #(.XLEN(32), .ENTRIES(32), .CTR_BITS(2), .GHR_BITS(5), .MODE(0)) u_bim (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_advance(if_advance),
    .pred_taken(bim_taken), .pred_target(bim_target), .pred_ghr(bim_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .upd_ghr(upd_ghr), .perf_updates(bim_updates), .perf_mispred(bim_mispred)
  );

  branch_predictor_btb #(.XLEN(32), .ENTRIES(32), .CTR_BITS(2), .GHR_BITS(5), .MODE(1)) u_gs (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_advance(if_advance),
    .pred_taken(gs_taken), .pred_target(gs_target), .pred_ghr(gs_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .upd_ghr(upd_ghr), .perf_updates(gs_updates), .perf_mispred(gs_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One EX resolution, applied across exactly one rising edge.
  task automatic resolve(input logic [31:0] pc, input logic is_cond, input logic taken,
                         input logic [31:0] target, input logic mis, input logic [4:0] ghr);
    upd_pc = pc; upd_is_cond = is_cond; upd_taken = taken;
    upd_target = target; upd_mispredict = mis; upd_ghr = ghr;
    upd_valid = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_pc = 32'h0; if_advance = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_is_cond = 1'b0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_mispredict = 1'b0; upd_ghr = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and asynchronous reset clearing a live prediction.
    if_pc = 32'h40; #1;
    check("rst_pred_taken", 32'(bim_taken), 32'd0);
    check("rst_pred_ghr", 32'(bim_ghr), 32'd0);
    check("rst_perf_updates", bim_updates, 32'd0);
    check("rst_perf_mispred", bim_mispred, 32'd0);
    resolve(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 5'd0);
    check("jal_before_async_rst", 32'(bim_taken), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_bim_taken", 32'(bim_taken), 32'd0);
    check("async_rst_perf_updates", bim_updates, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Bimodal training: counter 1 -> 2 -> 3.
    do_reset();
    if_pc = 32'h40; #1;
    check("train_cold_miss", 32'(bim_taken), 32'd0);
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    check("train_ctr2_taken", 32'(bim_taken), 32'd1);
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    check("train_ctr3_taken", 32'(bim_taken), 32'd1);
    check("train_target", bim_target, 32'h80);
    check("train_perf_updates", bim_updates, 32'd2);

    // Saturation at the top, then at the bottom.
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    resolve(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    check("sat_hi_then_nt_taken", 32'(bim_taken), 32'd1);
    check("nt_keeps_target", bim_target, 32'h80);
    resolve(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    check("ctr1_not_taken", 32'(bim_taken), 32'd0);
    repeat (4) resolve(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    check("sat_lo_ctr1", 32'(bim_taken), 32'd0);
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    check("sat_lo_ctr2", 32'(bim_taken), 32'd1);
    check("sat_perf_updates", bim_updates, 32'd12);

    // Alias: 0xC0 shares index 16 with 0x40 but has a different tag.
    if_pc = 32'hC0; #1;
    check("alias_miss", 32'(bim_taken), 32'd0);
    if_pc = 32'h40; #1;
    check("alias_owner_hit", 32'(bim_taken), 32'd1);

    // jal: allocates, predicts taken regardless of counter, leaves PHT/GHR alone.
    do_reset();
    resolve(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 5'b11111);
    if_pc = 32'h100; #1;
    check("jal_pred_taken", 32'(bim_taken), 32'd1);
    check("jal_pred_target", bim_target, 32'h200);
    check("jal_ghr_kept", 32'(bim_ghr), 32'd0);
    resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 5'd0);
    resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
    check("jal_pht_untouched", 32'(bim_taken), 32'd0);
    check("jal_no_mispred", bim_mispred, 32'd0);
    resolve(32'h100, 1'b0, 1'b1, 32'h200, 1'b1, 5'b10110);
    check("jal_repair_ghr", 32'(bim_ghr), 32'b10110);
    check("jal_repair_mispred", bim_mispred, 32'd1);

    // gshare: repair beats a coinciding speculative shift.
    do_reset();
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    resolve(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 5'd0);
    if_pc = 32'h40; #1;
    check("gs_hit_taken", 32'(gs_taken), 32'd1);
    check("gs_ghr_zero", 32'(gs_ghr), 32'd0);
    if_advance = 1'b1;
    resolve(32'h60, 1'b1, 1'b0, 32'h0, 1'b1, 5'b00101);
    if_advance = 1'b0; #1;
    check("gs_repair_ghr", 32'(gs_ghr), 32'b01010);
    check("gs_perf_mispred", gs_mispred, 32'd1);
    check("gs_perf_updates", gs_updates, 32'd3);
    check("gs_hist_index_nt", 32'(gs_taken), 32'd0);
    check("bim_same_pc_taken", 32'(bim_taken), 32'd1);
    if_advance = 1'b1;
    @(posedge clk); #1;
    if_advance = 1'b0; #1;
    check("gs_spec_shift", 32'(gs_ghr), 32'b10100);
    check("bim_spec_shift", 32'(bim_ghr), 32'b10101);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
